alu16_seq: RTL and testbench
============================

ALU16_SEQ -- requirements
Module: alu16_seq

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  request; sampled only in IDLE.
REQ-004 op  input  3  000 ADD16, 001 ADC16, 010 SUB16, 011 SBC16, 100 INC16, 101 DEC16, 110/111 reserved.
REQ-005 opA  input  16  first operand; captured on accepted start.
REQ-006 opB  input  16  second operand; captured on accepted start; ignored for INC16/DEC16.
REQ-007 flagsIn  input  8  current F register; captured on accepted start; Z=bit7, N=bit6, H=bit5, C=bit4.
REQ-008 aluA, aluB  output  8 each  operands driven to the external alu8.
REQ-009 aluOp  output  4  alu8 opcode: ADD 0000, ADC 0001, SUB 0010, SBC 0011.
REQ-010 aluCarryIn  output  1  carry/borrow into alu8.
REQ-011 aluRes  input  8  alu8 result, combinational from aluA/aluB/aluOp/aluCarryIn.
REQ-012 aluFlags  input  8  alu8 flags, same bit layout as flagsIn.
REQ-013 busy  output  1  high in LOW, HIGH, DONE.
REQ-014 done  output  1  one-cycle pulse; result and flagsOut valid.
REQ-015 result  output  16  registered 16-bit result; holds until next done.
REQ-016 flagsOut  output  8  registered flags; bits 3:0 always 0.

Function
REQ-017 FSM states IDLE, LOW, HIGH, DONE; IDLE->LOW on start; LOW->HIGH; HIGH->DONE; DONE->IDLE unconditionally.
REQ-018 Fixed latency: start accepted at edge N; done high in cycle N+3; new start accepted earliest in cycle N+4.
REQ-019 start while busy is ignored; operands and flags captured earlier are not disturbed.
REQ-020 LOW: aluA=opA[7:0]; aluB=opB[7:0] (0x01 for INC16/DEC16); end of cycle, result[7:0]<=aluRes and low carry<=aluFlags[4].
REQ-021 LOW aluOp/aluCarryIn: ADD16,INC16 ADD/0; ADC16 ADC/flagsIn C; SUB16,DEC16 SUB/0; SBC16 SBC/flagsIn C.
REQ-022 HIGH: aluA=opA[15:8]; aluB=opB[15:8] (0x00 for INC16/DEC16); aluOp ADC for add-type ops, SBC for subtract-type ops; aluCarryIn=low carry; end of cycle, result[15:8]<=aluRes.
REQ-023 IDLE and DONE: aluA=aluB=0, aluOp=ADD, aluCarryIn=0.
REQ-024 ADD16/ADC16 flags: Z=flagsIn Z (preserved), N=0, H=high-byte aluFlags H (carry from bit 11), C=high-byte aluFlags C (carry from bit 15).
REQ-025 SUB16/SBC16 flags: Z=1 iff full 16-bit result==0x0000, N=1, H=high-byte borrow from bit 12, C=high-byte borrow from bit 16.
REQ-026 INC16/DEC16: flagsOut=flagsIn with bits 3:0 cleared; result wraps modulo 2^16 (0xFFFF+1=0x0000, 0x0000-1=0xFFFF).
REQ-027 Reserved op: same timing, result=opA, flagsOut=flagsIn with bits 3:0 cleared.
REQ-028 result and flagsOut update only on the HIGH->DONE edge; unchanged otherwise.

Reset
REQ-029 rst_n low asynchronously forces IDLE; busy=0, done=0, result=0x0000, flagsOut=0x00, internal latches cleared.
REQ-030 Reset asserted in any state aborts the operation; no done pulse is produced for it; first start after release behaves per REQ-018.

Verification
REQ-031 ADD16 opA=0x0FFF opB=0x0001 flagsIn=0x80 -> done at N+3, result=0x1000, flagsOut=0xA0.
REQ-032 ADD16 opA=0xFFFF opB=0x0001 flagsIn=0x00 -> result=0x0000, flagsOut=0x30 (Z preserved 0).
REQ-033 SBC16 opA=0x1000 opB=0x0001 flagsIn=0x10 -> result=0x0FFE, flagsOut=0x60; SUB16 opA=opB=0x1234 -> result=0x0000, flagsOut=0xC0.
REQ-034 INC16 opA=0xFFFF flagsIn=0xF0 -> result=0x0000, flagsOut=0xF0; DEC16 opA=0x0000 -> result=0xFFFF.
REQ-035 start pulsed in cycles N and N+1 with different operands -> only the first op executes; one done pulse; busy high N+1..N+3.
REQ-036 rst_n low during HIGH -> busy=0, result=0x0000 immediately; no done; following ADD16 0x0001+0x0001 -> result=0x0002.
REQ-037 Bench compares result and flagsOut against a 16-bit reference model over 1000 random ops/operands/flagsIn.

Source files
------------

// File: rtl/alu16_seq.sv
// Sequential 16-bit add/subtract/increment/decrement built on an external 8-bit ALU.
// Each operation takes a low-byte pass and then a high-byte pass that consumes the low-byte carry.
module alu16_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [15:0] opA,
    input  logic [15:0] opB,
    input  logic [7:0]  flagsIn,
    output logic [7:0]  aluA,
    output logic [7:0]  aluB,
    output logic [3:0]  aluOp,
    output logic        aluCarryIn,
    input  logic [7:0]  aluRes,
    input  logic [7:0]  aluFlags,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [7:0]  flagsOut
);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpAdc = 3'b001;
    localparam logic [2:0] OpSub = 3'b010;
    localparam logic [2:0] OpSbc = 3'b011;
    localparam logic [2:0] OpInc = 3'b100;
    localparam logic [2:0] OpDec = 3'b101;

    localparam logic [3:0] AluAdd = 4'b0000;
    localparam logic [3:0] AluAdc = 4'b0001;
    localparam logic [3:0] AluSub = 4'b0010;
    localparam logic [3:0] AluSbc = 4'b0011;

    typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [3:0]  f_q, f_d;          // captured Z N H C
    logic [7:0]  lo_q, lo_d;
    logic        carry_q, carry_d;
    logic [15:0] result_q, result_d;
    logic [7:0]  flags_q, flags_d;

    logic        is_sub, is_unary, use_carry, is_rsvd;
    logic [15:0] sum16;

    logic unused_inputs;
    assign unused_inputs = ^{aluFlags[7:6], aluFlags[3:0], flagsIn[3:0]};

    assign is_sub    = (op_q == OpSub) || (op_q == OpSbc) || (op_q == OpDec);
    assign is_unary  = (op_q == OpInc) || (op_q == OpDec);
    assign use_carry = (op_q == OpAdc) || (op_q == OpSbc);
    assign is_rsvd   = (op_q[2:1] == 2'b11);
    assign sum16     = {aluRes, lo_q};

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        f_d        = f_q;
        lo_d       = lo_q;
        carry_d    = carry_q;
        result_d   = result_q;
        flags_d    = flags_q;
        aluA       = 8'h00;
        aluB       = 8'h00;
        aluOp      = AluAdd;
        aluCarryIn = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLow;
                    op_d    = op;
                    a_d     = opA;
                    b_d     = opB;
                    f_d     = flagsIn[7:4];
                end
            end
            StLow: begin
                aluA = a_q[7:0];
                aluB = is_unary ? 8'h01 : b_q[7:0];
                if (is_sub) begin
                    aluOp = use_carry ? AluSbc : AluSub;
                end else begin
                    aluOp = use_carry ? AluAdc : AluAdd;
                end
                aluCarryIn = use_carry & f_q[0];
                lo_d       = aluRes;
                carry_d    = aluFlags[4];
                state_d    = StHigh;
            end
            StHigh: begin
                aluA       = a_q[15:8];
                aluB       = is_unary ? 8'h00 : b_q[15:8];
                aluOp      = is_sub ? AluSbc : AluAdc;
                aluCarryIn = carry_q;
                result_d   = is_rsvd ? a_q : sum16;
                if (is_rsvd || is_unary) begin
                    flags_d = {f_q, 4'b0000};
                end else if (is_sub) begin
                    flags_d = {(sum16 == 16'h0000), 1'b1, aluFlags[5], aluFlags[4], 4'b0000};
                end else begin
                    // Z is carried through unchanged for 16-bit adds
                    flags_d = {f_q[3], 1'b0, aluFlags[5], aluFlags[4], 4'b0000};
                end
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= 3'b000;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            f_q      <= 4'h0;
            lo_q     <= 8'h00;
            carry_q  <= 1'b0;
            result_q <= 16'h0000;
            flags_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            f_q      <= f_d;
            lo_q     <= lo_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign result   = result_q;
    assign flagsOut = flags_q;

endmodule

// File: tb/tb_alu16_seq.sv
// Bench for alu16_seq: behavioural alu8 beside the DUT, a 16-bit reference model and a
// scoreboard queue popped whenever done is seen.
module tb_alu16_seq;

    typedef struct packed {
        logic [15:0] res;
        logic [7:0]  flags;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [15:0] opA;
    logic [15:0] opB;
    logic [7:0]  flagsIn;
    logic [7:0]  aluA;
    logic [7:0]  aluB;
    logic [3:0]  aluOp;
    logic        aluCarryIn;
    logic [7:0]  aluRes;
    logic [7:0]  aluFlags;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [7:0]  flagsOut;

    int   n_checks = 0;
    int   n_fails  = 0;
    int   n_done   = 0;
    exp_t sb_q[$];
    logic [15:0] last_res   = 16'h0000;
    logic [7:0]  last_flags = 8'h00;

    alu16_seq u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .opA        (opA),
        .opB        (opB),
        .flagsIn    (flagsIn),
        .aluA       (aluA),
        .aluB       (aluB),
        .aluOp      (aluOp),
        .aluCarryIn (aluCarryIn),
        .aluRes     (aluRes),
        .aluFlags   (aluFlags),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .flagsOut   (flagsOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural alu8: H is nibble carry/borrow, C is byte carry/borrow.
    always_comb begin
        int ci, s, hs;
        logic h, c;
        ci       = 0;
        s        = 0;
        hs       = 0;
        h        = 1'b0;
        c        = 1'b0;
        aluRes   = 8'h00;
        if (aluOp == 4'b0001 || aluOp == 4'b0011) ci = int'(aluCarryIn);
        if (aluOp == 4'b0010 || aluOp == 4'b0011) begin
            s  = int'(aluA) - int'(aluB) - ci;
            c  = int'(aluA) < int'(aluB) + ci;
            h  = int'(aluA[3:0]) < int'(aluB[3:0]) + ci;
        end else begin
            s  = int'(aluA) + int'(aluB) + ci;
            hs = int'(aluA[3:0]) + int'(aluB[3:0]) + ci;
            c  = s > 255;
            h  = hs > 15;
        end
        aluRes   = s[7:0];
        aluFlags = {(s[7:0] == 8'h00), s[7], h, c, 4'b0000};
    end

    function automatic exp_t ref_model(input logic [2:0] o, input logic [15:0] a,
                                       input logic [15:0] b, input logic [7:0] f);
        exp_t e;
        int   ci, s;
        logic h, c;
        ci = (o == 3'b001 || o == 3'b011) ? int'(f[4]) : 0;
        case (o)
            3'b000, 3'b001: begin
                s = int'(a) + int'(b) + ci;
                h = (int'(a[11:0]) + int'(b[11:0]) + ci) > 4095;
                c = s > 65535;
                e.res   = s[15:0];
                e.flags = {f[7], 1'b0, h, c, 4'b0000};
            end
            3'b010, 3'b011: begin
                s = int'(a) - int'(b) - ci;
                h = int'(a[11:0]) < int'(b[11:0]) + ci;
                c = int'(a) < int'(b) + ci;
                e.res   = s[15:0];
                e.flags = {(s[15:0] == 16'h0000), 1'b1, h, c, 4'b0000};
            end
            3'b100: begin
                e.res   = a + 16'h0001;
                e.flags = {f[7:4], 4'b0000};
            end
            3'b101: begin
                e.res   = a - 16'h0001;
                e.flags = {f[7:4], 4'b0000};
            end
            default: begin
                e.res   = a;
                e.flags = {f[7:4], 4'b0000};
            end
        endcase
        return e;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboard consumer and hold check for result/flagsOut between done pulses.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_res   = 16'h0000;
            last_flags = 8'h00;
        end else if (done) begin
            n_done++;
            if (sb_q.size() == 0) begin
                check_val("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_val("result", {16'h0, result}, {16'h0, e.res});
                check_val("flagsOut", {24'h0, flagsOut}, {24'h0, e.flags});
            end
            last_res   = result;
            last_flags = flagsOut;
        end else begin
            check_val("result_hold", {8'h0, result, flagsOut}, {8'h0, last_res, last_flags});
        end
    end

    task automatic run_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                          input logic [7:0] f);
        @(negedge clk);
        start   = 1'b1;
        op      = o;
        opA     = a;
        opB     = b;
        flagsIn = f;
        @(posedge clk);
        sb_q.push_back(ref_model(o, a, b, f));
        #1;
        start   = 1'b0;
        op      = 3'($urandom);
        opA     = 16'($urandom);
        opB     = 16'($urandom);
        flagsIn = 8'($urandom);
        @(negedge clk);
        check_val("low_busy_done", {30'h0, busy, done}, 32'h2);
        check_val("low_aluA", {24'h0, aluA}, {24'h0, a[7:0]});
        @(negedge clk);
        check_val("high_busy_done", {30'h0, busy, done}, 32'h2);
        check_val("high_aluA", {24'h0, aluA}, {24'h0, a[15:8]});
        @(negedge clk);
        check_val("done_latency", {30'h0, busy, done}, 32'h3);
        check_val("done_alu_idle", {11'h0, aluA, aluB, aluOp, aluCarryIn}, 32'h0);
        @(negedge clk);
        check_val("idle_busy_done", {30'h0, busy, done}, 32'h0);
        check_val("idle_alu_idle", {11'h0, aluA, aluB, aluOp, aluCarryIn}, 32'h0);
    endtask

    initial begin
        int dones_before;
        rst_n   = 1'b0;
        start   = 1'b0;
        op      = 3'b000;
        opA     = 16'h0000;
        opB     = 16'h0000;
        flagsIn = 8'h00;
        repeat (3) @(negedge clk);
        check_val("reset_state", {7'h0, busy, done, result, flagsOut}, 32'h0);
        check_val("reset_alu", {11'h0, aluA, aluB, aluOp, aluCarryIn}, 32'h0);
        rst_n = 1'b1;

        // Directed vectors
        run_op(3'b000, 16'h0FFF, 16'h0001, 8'h80);
        run_op(3'b000, 16'hFFFF, 16'h0001, 8'h00);
        run_op(3'b011, 16'h1000, 16'h0001, 8'h10);
        run_op(3'b010, 16'h1234, 16'h1234, 8'h00);
        run_op(3'b100, 16'hFFFF, 16'h5555, 8'hF0);
        run_op(3'b101, 16'h0000, 16'hAAAA, 8'h3F);
        run_op(3'b001, 16'h00FF, 16'h0000, 8'h10);
        run_op(3'b110, 16'hBEEF, 16'h1111, 8'hFF);
        run_op(3'b111, 16'h1234, 16'h4321, 8'h5A);
        run_op(3'b101, 16'h0000, 16'h0000, 8'h00);

        // Start held across the first cycle of busy: second request must be dropped
        dones_before = n_done;
        @(negedge clk);
        start = 1'b1; op = 3'b000; opA = 16'h1111; opB = 16'h2222; flagsIn = 8'h00;
        @(posedge clk);
        sb_q.push_back(ref_model(3'b000, 16'h1111, 16'h2222, 8'h00));
        @(negedge clk);
        check_val("dbl_busy1", {31'h0, busy}, 32'h1);
        op = 3'b010; opA = 16'h9999; opB = 16'h0F0F; flagsIn = 8'hF0;
        @(negedge clk);
        start = 1'b0;
        check_val("dbl_busy2", {30'h0, busy, done}, 32'h2);
        @(negedge clk);
        check_val("dbl_busy3", {30'h0, busy, done}, 32'h3);
        repeat (3) @(negedge clk);
        check_val("dbl_one_done", n_done - dones_before, 32'd1);

        // Reset while in HIGH aborts the operation
        dones_before = n_done;
        @(negedge clk);
        start = 1'b1; op = 3'b000; opA = 16'h7000; opB = 16'h0123; flagsIn = 8'h00;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("abort_state", {7'h0, busy, done, result, flagsOut}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_val("abort_no_done", n_done - dones_before, 32'd0);
        run_op(3'b000, 16'h0001, 16'h0001, 8'h00);

        // Random sweep against the reference model
        for (int i = 0; i < 1000; i++) begin
            run_op(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 8'($urandom));
        end

        repeat (2) @(negedge clk);
        check_val("sb_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
